// File: rtl/free_list_ckpt.sv
// free_list_ckpt: circular physical-register free list for the rename stage.
// Grants one free preg per cycle and accepts one freed preg per cycle from
// commit. Head/tail/count are exported for the rename checkpoint snapshot.
// On recovery the head and count are restored from the checkpoint, and the
// frees committed since that checkpoint are kept, because the commit stream
// is always older than the mispredicted branch.
// Optional build macro: FREE_LIST_CHECK_EN enables the sticky err_o
// overflow/underflow detector and the matching simulation checks.

module free_list_ckpt #(
    parameter int AREG   = 32,
    parameter int PREGS  = 64,
    parameter int PREG_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [PREG_W-1:0] alloc_preg_o,
    input  logic              free_valid_i,
    input  logic [PREG_W-1:0] free_preg_i,
    input  logic              recover_i,
    input  logic [PREG_W-1:0] recover_head_i,
    input  logic [PREG_W-1:0] recover_tail_i,
    input  logic [PREG_W:0]   recover_free_count_i,
    output logic [PREG_W-1:0] chkpt_head_o,
    output logic [PREG_W-1:0] chkpt_tail_o,
    output logic [PREG_W:0]   chkpt_free_count_o,
    output logic              empty_o,
    output logic              err_o
);

    // Number of pregs not mapped by the RAT at reset; the list never holds more.
    localparam int              CAP   = PREGS - AREG;
    localparam logic [PREG_W:0] CAP_C = (PREG_W + 1)'(CAP);

    logic [PREG_W-1:0] fl_mem_q [PREGS];
    logic [PREG_W-1:0] head_q, head_d;
    logic [PREG_W-1:0] tail_q, tail_d;
    logic [PREG_W:0]   count_q, count_d;
    logic [PREG_W-1:0] delta_s;
    logic              grant_s;

    // Grant is blocked while recovering, because head is being rewritten.
    assign grant_s      = alloc_req_i & (count_q != {(PREG_W + 1){1'b0}}) & ~recover_i;
    assign alloc_gnt_o  = grant_s;
    assign alloc_preg_o = fl_mem_q[head_q];
    assign empty_o      = (count_q == {(PREG_W + 1){1'b0}});

    assign chkpt_head_o       = head_q;
    assign chkpt_tail_o       = tail_q;
    assign chkpt_free_count_o = count_q;

    // Entries freed since the checkpoint: tail only moves on commit frees.
    assign delta_s = tail_q - recover_tail_i;

    // Next-state for head, tail and count from alloc, free and recovery.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (free_valid_i) begin
            tail_d = tail_q + {{(PREG_W - 1){1'b0}}, 1'b1};
        end else begin
            tail_d = tail_q;
        end
        if (recover_i) begin
            head_d  = recover_head_i;
            count_d = recover_free_count_i + {1'b0, delta_s}
                    + {{PREG_W{1'b0}}, free_valid_i};
        end else begin
            head_d  = grant_s ? head_q + {{(PREG_W - 1){1'b0}}, 1'b1} : head_q;
            count_d = count_q + {{PREG_W{1'b0}}, free_valid_i}
                    - {{PREG_W{1'b0}}, grant_s};
        end
    end

    // Pointer and count registers; reset maps pregs AREG..PREGS-1 as free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= {PREG_W{1'b0}};
            tail_q  <= PREG_W'(CAP);
            count_q <= CAP_C;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Free-list storage: commit frees are written at tail, no bypass to head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PREGS; i++) begin
                fl_mem_q[i] <= (i < CAP) ? PREG_W'(i + AREG) : {PREG_W{1'b0}};
            end
        end else if (free_valid_i) begin
            fl_mem_q[tail_q] <= free_preg_i;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic ovf_s, rec_ovf_s, udf_s;
    logic err_q;

    assign ovf_s     = free_valid_i & (count_q == CAP_C) & ~grant_s;
    assign rec_ovf_s = recover_i & (count_d > CAP_C);
    assign udf_s     = alloc_req_i & (count_q == {(PREG_W + 1){1'b0}}) & ~recover_i;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | ovf_s | rec_ovf_s | udf_s;
        end
    end

    assign err_o = err_q;

    free_list_ckpt_chk u_chk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ovf_i      (ovf_s),
        .rec_ovf_i  (rec_ovf_s),
        .udf_i      (udf_s)
    );
`else
    assign err_o = 1'b0;
`endif

endmodule

`ifdef FREE_LIST_CHECK_EN
// Simulation-only checks mirroring the err_o conditions.
module free_list_ckpt_chk (
    input logic clk_i,
    input logic rst_i,
    input logic ovf_i,
    input logic rec_ovf_i,
    input logic udf_i
);
    // Report each illegal event on the clock edge where it occurs.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!ovf_i)     else $warning("free_list_ckpt: free while list full");
            assert (!rec_ovf_i) else $warning("free_list_ckpt: recovered count too large");
            assert (!udf_i)     else $warning("free_list_ckpt: alloc request while empty");
        end
    end
endmodule
`endif
